// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default number of REQ cycles allowed before a memory timeout
    localparam int c_timeout_default = 15;

    // Fetch sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        REQ   = 3'd2,
        LATCH = 3'd3,
        INCR  = 3'd4,
        FAULT = 3'd5
    } state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_timeout.sv
`default_nettype none
// ============================================================================
// Module      : fetch_timeout
// Description : Saturating wait counter; flags the cycle on which the count
//               reaches TIMEOUT while counting is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout
    import fetch_pkg::*;
#(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    // Value held during the final allowed wait cycle
    localparam logic [TO_W-1:0] c_last = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_max  = {TO_W{1'b1}};

    logic [TO_W-1:0] r_count;

    // Count wait cycles, clear on request, hold at the all-ones ceiling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != c_max)) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    // The count reaches TIMEOUT on the edge that ends this cycle
    always_comb begin
        o_expired = i_count_en && (r_count >= c_last);
    end

endmodule : fetch_timeout
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq
// Description : Fetch sequencer for the program counter. Sequences counter
//               bus-enable, memory read handshake, IR load and counter
//               increment; faults permanently on a memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = c_timeout_default,
    parameter int TO_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              halt,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              pc_incr,
    output logic              mem_rd,
    output logic              ir_load,
    output logic              busy,
    output logic              fault,
    output logic [ADDR_W-1:0] fetch_cnt
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_fetch_cnt;
    logic              w_to_clear;
    logic              w_to_count;
    logic              w_to_expired;

    // The timeout counter only runs while waiting for memory in REQ
    assign w_to_count = (r_state == REQ);
    assign w_to_clear = (r_state != REQ);

    fetch_timeout #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_to_clear),
        .i_count_en (w_to_count),
        .o_expired  (w_to_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; run/halt are only looked at in IDLE and INCR so a
    // started fetch always completes
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (run && !halt) w_next_state = DRIVE;
            DRIVE:   w_next_state = REQ;
            REQ: begin
                // An ack on the expiry cycle still wins
                if (mem_ack)           w_next_state = LATCH;
                else if (w_to_expired) w_next_state = FAULT;
            end
            LATCH:   w_next_state = INCR;
            INCR:    w_next_state = (halt || !run) ? IDLE : DRIVE;
            FAULT:   w_next_state = FAULT;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded purely from the current state
    always_comb begin
        pc_en   = (r_state == DRIVE) || (r_state == REQ);
        mem_rd  = (r_state == REQ);
        ir_load = (r_state == LATCH);
        pc_incr = (r_state == INCR);
        busy    = (r_state != IDLE) && (r_state != FAULT);
        fault   = (r_state == FAULT);
    end

    // Completed-fetch counter, advances once per INCR and wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
        end else if (r_state == INCR) begin
            r_fetch_cnt <= r_fetch_cnt + ADDR_W'(1);
        end
    end

    assign fetch_cnt = r_fetch_cnt;

endmodule : fetch_seq
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_seq
// Description : Self-checking bench for fetch_seq. A narrow second instance
//               shares all inputs so fetch-counter wrap is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        halt = 1'b0;
    logic        mem_ack = 1'b0;

    logic        pc_en, pc_incr, mem_rd, ir_load, busy, fault;
    logic [15:0] fetch_cnt;

    logic        n_pc_en, n_pc_incr, n_mem_rd, n_ir_load, n_busy, n_fault;
    logic [3:0]  n_fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_ir[$];
    int exp_incr[$];
    int ack_delay = -1;
    logic ack_force = 1'b0;
    int req_n = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    fetch_seq #(.ADDR_W(16), .TIMEOUT(15), .TO_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .halt      (halt),
        .mem_ack   (mem_ack),
        .pc_en     (pc_en),
        .pc_incr   (pc_incr),
        .mem_rd    (mem_rd),
        .ir_load   (ir_load),
        .busy      (busy),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    fetch_seq #(.ADDR_W(4), .TIMEOUT(15), .TO_W(4)) dut_narrow (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .halt      (halt),
        .mem_ack   (mem_ack),
        .pc_en     (n_pc_en),
        .pc_incr   (n_pc_incr),
        .mem_rd    (n_mem_rd),
        .ir_load   (n_ir_load),
        .busy      (n_busy),
        .fault     (n_fault),
        .fetch_cnt (n_fetch_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and scoreboard monitor, both on the falling edge
    always @(negedge clk) begin
        if (mem_rd === 1'b1) req_n = req_n + 1;
        else                 req_n = 0;
        mem_ack = ack_force || ((mem_rd === 1'b1) && (ack_delay >= 0) && (req_n == ack_delay + 1));

        if (mon_en) begin
            if (ir_load === 1'b1) begin
                n_checks++;
                if (exp_ir.size() == 0) begin
                    n_fail++;
                    $display("FAIL ir_load_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    int e;
                    e = exp_ir.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL ir_load_cycle: got cycle %0d, expected %0d", cyc, e);
                    end
                end
            end
            if (pc_incr === 1'b1) begin
                n_checks++;
                if (exp_incr.size() == 0) begin
                    n_fail++;
                    $display("FAIL pc_incr_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    int e;
                    e = exp_incr.pop_front();
                    if (cyc !== e) begin
                        n_fail++;
                        $display("FAIL pc_incr_cycle: got cycle %0d, expected %0d", cyc, e);
                    end
                end
            end
            n_checks++;
            if ((pc_en & pc_incr) !== 1'b0) begin
                n_fail++;
                $display("FAIL en_incr_overlap: pc_en=%b pc_incr=%b at cycle %0d, expected not both 1", pc_en, pc_incr, cyc);
            end
            n_checks++;
            if ((mem_rd & ~pc_en) !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_without_en: mem_rd=%b pc_en=%b at cycle %0d, expected mem_rd only with pc_en", mem_rd, pc_en, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; halt = 1'b0;
        tick(2);
        mon_en = 1'b1;
        n_checks++;
        if ({pc_en, pc_incr, mem_rd, ir_load, busy, fault} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 000000", {pc_en, pc_incr, mem_rd, ir_load, busy, fault});
        end
        n_checks++;
        if (fetch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_fetch_cnt: got %0d, expected 0", fetch_cnt);
        end
        reset = 1'b0;
        tick(1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_run: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        ack_delay = 0;
        c = cyc;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_ir.push_back(c + 3 + 4 * k);
            exp_incr.push_back(c + 4 + 4 * k);
        end
        while (cyc < c + 11) tick(1);
        run = 1'b0;
        while (cyc < c + 13) tick(1);
        n_checks++;
        if (fetch_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_fetch_cnt: got %0d, expected 3", fetch_cnt);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_ack_delay();
        int c, n_req, n_en;
        ack_delay = 5;
        c = cyc;
        run = 1'b1;
        exp_ir.push_back(c + 8);
        exp_incr.push_back(c + 9);
        tick(1);
        run = 1'b0;
        n_req = 0; n_en = 0;
        for (int i = 0; i < 12; i++) begin
            if (pc_en === 1'b1) n_en++;
            if ((pc_en & mem_rd) === 1'b1) n_req++;
            tick(1);
        end
        n_checks++;
        if (n_req != 6) begin
            n_fail++;
            $display("FAIL delay_req_cycles: got %0d, expected 6", n_req);
        end
        n_checks++;
        if (n_en != 7) begin
            n_fail++;
            $display("FAIL delay_pc_en_cycles: got %0d, expected 7", n_en);
        end
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL delay_fault: got %b, expected 0", fault);
        end
        n_checks++;
        if (fetch_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL delay_fetch_cnt: got %0d, expected 4", fetch_cnt);
        end
    endtask

    task automatic test_timeout();
        int c, n_req, first_fault;
        ack_delay = -1;
        c = cyc;
        run = 1'b1;
        tick(1);
        n_req = 0; first_fault = -1;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd === 1'b1) n_req++;
            if ((fault === 1'b1) && (first_fault < 0)) first_fault = cyc;
            tick(1);
        end
        n_checks++;
        if (n_req != 15) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got %0d, expected 15", n_req);
        end
        n_checks++;
        if (first_fault != c + 17) begin
            n_fail++;
            $display("FAIL timeout_fault_cycle: got %0d, expected %0d", first_fault, c + 17);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_busy: got %b, expected 0", busy);
        end
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            ack_force = i[1];
            tick(1);
            n_checks++;
            if ({fault, busy, pc_en, mem_rd} !== 4'b1000) begin
                n_fail++;
                $display("FAIL fault_sticky: fault/busy/pc_en/mem_rd=%b, expected 1000", {fault, busy, pc_en, mem_rd});
            end
        end
        ack_force = 1'b0;
        run = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks++;
        if ({fault, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL fault_reset: fault/busy=%b, expected 00", {fault, busy});
        end
        n_checks++;
        if (fetch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL fault_reset_cnt: got %0d, expected 0", fetch_cnt);
        end
    endtask

    task automatic test_halt();
        int c, n_en;
        ack_delay = 3;
        c = cyc;
        run = 1'b1;
        exp_ir.push_back(c + 6);
        exp_incr.push_back(c + 7);
        tick(2);
        halt = 1'b1;
        tick(6);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_idle: busy=%b, expected 0", busy);
        end
        n_checks++;
        if (fetch_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL halt_fetch_cnt: got %0d, expected 1", fetch_cnt);
        end
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            if (pc_en !== 1'b0) n_en++;
            tick(1);
        end
        n_checks++;
        if (n_en != 0) begin
            n_fail++;
            $display("FAIL halt_no_pc_en: got %0d pc_en cycles, expected 0", n_en);
        end
        halt = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_wrap();
        int c;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        ack_delay = 0;
        c = cyc;
        run = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_ir.push_back(c + 3 + 4 * k);
            exp_incr.push_back(c + 4 + 4 * k);
        end
        while (cyc < c + 61) tick(1);
        n_checks++;
        if (n_fetch_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_at_max: got %0d, expected 15", n_fetch_cnt);
        end
        while (cyc < c + 63) tick(1);
        run = 1'b0;
        while (cyc < c + 65) tick(1);
        n_checks++;
        if (n_fetch_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %0d, expected 0", n_fetch_cnt);
        end
        n_checks++;
        if (fetch_cnt !== 16'd16) begin
            n_fail++;
            $display("FAIL wrap_wide_cnt: got %0d, expected 16", fetch_cnt);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int c;
        ack_delay = -1;
        run = 1'b1;
        tick(3);
        n_checks++;
        if (mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_in_req: mem_rd=%b, expected 1", mem_rd);
        end
        reset = 1'b1;
        run = 1'b0;
        tick(1);
        n_checks++;
        if ({pc_en, pc_incr, mem_rd, ir_load, busy, fault} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b, expected 000000", {pc_en, pc_incr, mem_rd, ir_load, busy, fault});
        end
        n_checks++;
        if (fetch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_cnt: got %0d, expected 0", fetch_cnt);
        end
        reset = 1'b0;
        ack_force = 1'b1;
        tick(2);
        ack_force = 1'b0;
        n_checks++;
        if ({busy, ir_load, pc_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL late_ack_ignored: busy/ir_load/pc_en=%b, expected 000", {busy, ir_load, pc_en});
        end
        ack_delay = 0;
        c = cyc;
        run = 1'b1;
        exp_ir.push_back(c + 3);
        exp_incr.push_back(c + 4);
        tick(1);
        run = 1'b0;
        n_checks++;
        if ({pc_en, mem_rd} !== 2'b10) begin
            n_fail++;
            $display("FAIL restart_drive: pc_en/mem_rd=%b, expected 10", {pc_en, mem_rd});
        end
        tick(5);
        n_checks++;
        if ({busy, fetch_cnt} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL restart_complete: busy=%b fetch_cnt=%0d, expected busy=0 fetch_cnt=1", busy, fetch_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_ack_delay();
        test_timeout();
        test_halt();
        test_wrap();
        test_reset_mid_fetch();
        tick(2);
        n_checks++;
        if ((exp_ir.size() != 0) || (exp_incr.size() != 0)) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d ir_load and %0d pc_incr pending, expected 0 and 0", exp_ir.size(), exp_incr.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_seq
`default_nettype wire

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer for the 16-bit program counter.
- Drives the counter's bus-enable and increment controls, issues a read handshake to instruction memory, and pulses the instruction-register load.
- Sits between the top-level run/halt control and the program counter on the shared tri-state address bus.
- Owns all timing between "counter drives bus", "memory returns data" and "counter advances".

Parameters:
- ADDR_W, 16, width of the program counter / fetch counter.
- TIMEOUT, 15, maximum cycles spent waiting for mem_ack before faulting (1..2^TO_W-1).
- TO_W, 4, width of the wait-timeout counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = keep fetching.
- halt  in  1  level; stop after the current fetch completes.
- mem_ack  in  1  memory read data valid, single-cycle pulse.
- pc_en  out  1  to counter en: counter drives its value onto the address bus one cycle later.
- pc_incr  out  1  to counter incr: counter advances by 1 on the next edge.
- mem_rd  out  1  read request to instruction memory.
- ir_load  out  1  one-cycle pulse; instruction register captures the data bus.
- busy  out  1  1 in any state other than IDLE and FAULT.
- fault  out  1  sticky memory-timeout flag.
- fetch_cnt  out  ADDR_W  completed fetches, wraps.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state = IDLE; pc_en, pc_incr, mem_rd, ir_load, busy and fault = 0; fetch_cnt = 0; timeout counter = 0.
  - Reset takes priority over all inputs, including mid-fetch and FAULT.
- All outputs are registered, i.e. decoded from the current state; no combinational input-to-output paths.
- States:
  - IDLE: all strobes 0.
    - run=1 and halt=0 -> DRIVE.
  - DRIVE: pc_en=1, mem_rd=0.
    - Always -> REQ. This covers the counter's one-cycle registered enable latency.
  - REQ: pc_en=1, mem_rd=1.
    - Timeout counter increments each cycle in REQ.
    - mem_ack=1 -> LATCH.
    - Counter reaching TIMEOUT with no ack -> FAULT.
    - mem_ack on the same cycle the counter reaches TIMEOUT counts as success.
  - LATCH: ir_load=1, pc_en=0, mem_rd=0; timeout counter cleared.
    - Always -> INCR.
  - INCR: pc_incr=1; fetch_cnt += 1, wrapping 2^ADDR_W-1 -> 0.
    - Leaves to IDLE if halt=1 or run=0.
    - Otherwise leaves to DRIVE.
  - FAULT: fault=1, busy=0, all strobes 0.
    - Exits only via reset.
- Fetch length: 4 cycles minimum per fetch (DRIVE, REQ with immediate ack, LATCH, INCR).
  - Back-to-back fetches produce one ir_load every 4 cycles.
- Halt/run:
  - Halt or run deassertion in DRIVE, REQ or LATCH never aborts the fetch; it is sampled only in INCR (and in IDLE).
  - halt=1 dominates run=1.
- mem_ack outside REQ is ignored and does not advance state or affect the counters.
- pc_en and pc_incr are never both 1 in the same cycle.
- mem_rd=1 only while pc_en=1.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, DRIVE, REQ, LATCH, INCR, FAULT}, 3-bit encoding;
  - the default TIMEOUT constant.
- One sub-module, fetch_timeout: a TO_W-bit saturating counter.
  - Inputs: clear, count enable.
  - Output: expired flag.
- The FSM and fetch_cnt remain in fetch_seq.

Test Plan:
- Reset, then run=1 with mem_ack pulsed on the first REQ cycle, for 3 fetches:
  - ir_load pulses at cycles 3, 7 and 11 after leaving IDLE;
  - pc_incr pulses one cycle after each ir_load;
  - fetch_cnt=3.
- mem_ack delayed 5 cycles into REQ:
  - pc_en and mem_rd stay high for 6 REQ cycles;
  - one ir_load, then one pc_incr;
  - fault=0.
- mem_ack never arrives, TIMEOUT=15:
  - fault rises after 15 REQ cycles and busy drops;
  - fault stays 1 despite run toggling and mem_ack pulses;
  - reset clears it.
- halt asserted during REQ:
  - fetch completes (ir_load, pc_incr each once);
  - state returns to IDLE;
  - no further pc_en.
- Preload fetch_cnt by running 65535 fetches (or force), then one more fetch:
  - fetch_cnt wraps to 0.
- Reset asserted during REQ:
  - next cycle all outputs 0 and state IDLE;
  - a mem_ack arriving afterwards is ignored;
  - run=1 restarts at DRIVE.
